// File: rtl/mem_port_arbiter_pkg.sv
// mem_pkg: shared constants and types for the memory port arbiter.
//   MEM_BASE / MEM_AW : location and size of the 128 MB memory window
//   FETCH_STRB        : byte enables driven for an instruction fetch
//   slot_state_e      : state of a per-requester response slot
//   in_window()       : address lies inside the memory window
//   strb_mask()       : expands byte enables into a 64-bit bit mask
package mem_pkg;

   localparam logic [63:0] MEM_BASE   = 64'h0000_0000_8000_0000;
   localparam int          MEM_AW     = 27;
   localparam logic [7:0]  FETCH_STRB = 8'h0F;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic logic in_window(input logic [63:0] addr);
      return addr[63:MEM_AW] == MEM_BASE[63:MEM_AW];
   endfunction

   function automatic logic [63:0] strb_mask(input logic [7:0] strb);
      logic [63:0] m;
      m = '0;
      for (int b = 0; b < 8; b++) begin
         m[8*b +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: all request, response and memory-port signals of the
// arbiter, plus debug visibility of its internal state.
//   i_*    : instruction-fetch request / response
//   d_*    : load/store request / response
//   m_*    : the shared memory port (m_rdata is combinational from memory)
//   i_slot_state, d_slot_state, last_d : debug view of slot FSMs and tie flag
// Handshakes: a request is held stable while X_req is high and is consumed in
// the cycle X_gnt is high. A response is transferred in every cycle where
// X_rvalid and X_rready are both high; X_rdata/X_err are stable while X_rvalid
// is high and X_rready is low.
// Modports: slave = the arbiter, master = requesters plus memory.
interface mem_port_arbiter_if;
   import mem_pkg::*;

   logic        i_req;
   logic [63:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic        i_rready;
   logic [31:0] i_rdata;
   logic        i_err;

   logic        d_req;
   logic        d_wr;
   logic [7:0]  d_strb;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic        d_rready;
   logic [63:0] d_rdata;
   logic        d_err;

   logic        m_en;
   logic        m_wr;
   logic [7:0]  m_strb;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic [63:0] m_rdata;

   slot_state_e i_slot_state;
   slot_state_e d_slot_state;
   logic        last_d;

   modport slave (
      input  i_req, i_addr, i_rready,
      output i_gnt, i_rvalid, i_rdata, i_err,
      input  d_req, d_wr, d_strb, d_addr, d_wdata, d_rready,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output m_en, m_wr, m_strb, m_addr, m_wdata,
      input  m_rdata,
      output i_slot_state, d_slot_state, last_d
   );

   modport master (
      output i_req, i_addr, i_rready,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      output d_req, d_wr, d_strb, d_addr, d_wdata, d_rready,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  m_en, m_wr, m_strb, m_addr, m_wdata,
      output m_rdata,
      input  i_slot_state, d_slot_state, last_d
   );

endinterface

// File: rtl/mem_port_arbiter_resp_slot.sv
// mem_resp_slot: one-entry registered response buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_data/load_err this cycle (request granted)
//   load_data  : response data to capture
//   load_err   : response error bit to capture
//   rready     : consumer accepts the held response
//   rvalid     : a response is held
//   rdata, err : the held response (only change on load)
//   state      : slot FSM state (debug)
module mem_resp_slot
   import mem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          load_err,
   input  logic          rready,
   output logic          rvalid,
   output logic [DW-1:0] rdata,
   output logic          err,
   output slot_state_e   state
);

   slot_state_e   state_q, state_d;
   logic [DW-1:0] data_q, data_d;
   logic          err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // A load always wins: it covers both filling an empty slot and refilling a
   // slot that is being drained in the same cycle.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      err_d   = err_q;
      if (load) begin
         state_d = SLOT_FULL;
         data_d  = load_data;
         err_d   = load_err;
      end else if (state_q == SLOT_FULL && rready) begin
         state_d = SLOT_EMPTY;
      end
   end

   assign rvalid = (state_q == SLOT_FULL);
   assign rdata  = data_q;
   assign err    = err_q;
   assign state  = state_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and load/store. Per-cycle round-robin grant, window range check,
// combinational drive of the memory port in the granted cycle, and one
// registered response slot per requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response/memory-port signals (slave modport)
module mem_port_arbiter
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   // last_d set means fetch took the most recent grant, so data owns the next
   // tie; it clears whenever data is granted. Its reset value 0 therefore hands
   // the first tie after reset to fetch.
   logic        last_d_q, last_d_d;
   logic        i_inwin, d_inwin;
   logic        i_elig, d_elig;
   logic        i_gnt, d_gnt;
   logic        i_rvalid, d_rvalid;
   logic [31:0] i_load_data;
   logic [63:0] d_load_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d_q <= 1'b0;
      end else begin
         last_d_q <= last_d_d;
      end
   end

   always_comb begin
      i_inwin = in_window(bus.i_addr);
      d_inwin = in_window(bus.d_addr);
      // A side may be granted only if its slot is free or drains this cycle.
      i_elig  = bus.i_req && (!i_rvalid || bus.i_rready);
      d_elig  = bus.d_req && (!d_rvalid || bus.d_rready);

      i_gnt = 1'b0;
      d_gnt = 1'b0;
      // Gating with rst_n keeps the memory port quiet while reset is held.
      if (rst_n) begin
         if (i_elig && d_elig) begin
            i_gnt = !last_d_q;
            d_gnt = last_d_q;
         end else begin
            i_gnt = i_elig;
            d_gnt = d_elig;
         end
      end

      last_d_d = last_d_q;
      if (i_gnt) begin
         last_d_d = 1'b1;
      end else if (d_gnt) begin
         last_d_d = 1'b0;
      end
   end

   // Memory port: idle (all zero) unless an in-window request is granted.
   always_comb begin
      bus.m_en    = 1'b0;
      bus.m_wr    = 1'b0;
      bus.m_strb  = 8'h00;
      bus.m_addr  = 64'h0;
      bus.m_wdata = 64'h0;
      if (i_gnt && i_inwin) begin
         bus.m_en   = 1'b1;
         bus.m_strb = FETCH_STRB;
         bus.m_addr = bus.i_addr;
      end else if (d_gnt && d_inwin) begin
         bus.m_en    = 1'b1;
         bus.m_wr    = bus.d_wr;
         bus.m_strb  = bus.d_strb;
         bus.m_addr  = bus.d_addr;
         bus.m_wdata = bus.d_wdata;
      end
   end

   always_comb begin
      i_load_data = i_inwin ? bus.m_rdata[31:0] : 32'h0;
      d_load_data = (d_inwin && !bus.d_wr) ? (bus.m_rdata & strb_mask(bus.d_strb)) : 64'h0;
   end

   mem_resp_slot #(.DW(32)) u_i_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (i_gnt),
      .load_data (i_load_data),
      .load_err  (!i_inwin),
      .rready    (bus.i_rready),
      .rvalid    (i_rvalid),
      .rdata     (bus.i_rdata),
      .err       (bus.i_err),
      .state     (bus.i_slot_state)
   );

   mem_resp_slot #(.DW(64)) u_d_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (d_gnt),
      .load_data (d_load_data),
      .load_err  (!d_inwin),
      .rready    (bus.d_rready),
      .rvalid    (d_rvalid),
      .rdata     (bus.d_rdata),
      .err       (bus.d_err),
      .state     (bus.d_slot_state)
   );

   assign bus.i_gnt    = i_gnt;
   assign bus.d_gnt    = d_gnt;
   assign bus.i_rvalid = i_rvalid;
   assign bus.d_rvalid = d_rvalid;
   assign bus.last_d   = last_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// traffic; expected responses come from a reference memory array and are
// checked by a monitor that pops an expected queue on each response transfer.
module tb_mem_port_arbiter;
   import mem_pkg::*;

   localparam int          NW   = 64;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- memory model and reference memory ----------------
   function automatic logic [63:0] seed_word(input int i);
      logic [31:0] k;
      k = 32'(i);
      if (i == 0) return 64'h0000_0000_0000_0513;
      return {k * 32'h9E37_79B9, (k * 32'h85EB_CA6B) ^ 32'hC0FF_EE00};
   endfunction

   function automatic logic tb_in_win(input logic [63:0] a);
      return (a >= 64'h8000_0000) && (a <= 64'h87FF_FFFF);
   endfunction

   function automatic logic [63:0] tb_merge(input logic [63:0] old, input logic [63:0] nw,
                                            input logic [7:0] s);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   logic [63:0] mem_arr [NW];
   logic [63:0] ref_arr [NW];
   bit          mem_loaded;

   assign bus.m_rdata = mem_arr[bus.m_addr[8:3]];

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < NW; i++) mem_arr[i] <= seed_word(i);
         mem_loaded <= 1'b1;
      end else if (bus.m_en && bus.m_wr) begin
         mem_arr[bus.m_addr[8:3]] <= tb_merge(mem_arr[bus.m_addr[8:3]], bus.m_wdata, bus.m_strb);
      end
   end

   // ---------------- scoreboard queues ----------------
   logic [32:0] exp_i_q[$];
   logic [64:0] exp_d_q[$];

   // ---------------- driver state ----------------
   logic        i_pend, i_rr;
   logic [63:0] i_pa;
   logic        d_pend, d_pw, d_rr;
   logic [7:0]  d_ps;
   logic [63:0] d_pa, d_pd;
   logic        obs_i_gnt, obs_d_gnt, obs_m_en;

   task automatic apply();
      bus.i_req    = i_pend;
      bus.i_addr   = i_pend ? i_pa : 64'h0;
      bus.i_rready = i_rr;
      bus.d_req    = d_pend;
      bus.d_wr     = d_pend & d_pw;
      bus.d_strb   = d_pend ? d_ps : 8'h00;
      bus.d_addr   = d_pend ? d_pa : 64'h0;
      bus.d_wdata  = d_pend ? d_pd : 64'h0;
      bus.d_rready = d_rr;
   endtask

   // Grant observed: the request is consumed, its expected response queued.
   task automatic observe();
      obs_i_gnt = bus.i_gnt;
      obs_d_gnt = bus.d_gnt;
      obs_m_en  = bus.m_en;
      if (obs_i_gnt) begin
         if (!i_pend) chk("i_gnt_without_req", 1'b1, 1'b0);
         else begin
            if (tb_in_win(i_pa)) exp_i_q.push_back({1'b0, ref_arr[i_pa[8:3]][31:0]});
            else                 exp_i_q.push_back({1'b1, 32'h0});
            i_pend = 1'b0;
         end
      end
      if (obs_d_gnt) begin
         if (!d_pend) chk("d_gnt_without_req", 1'b1, 1'b0);
         else begin
            if (!tb_in_win(d_pa)) exp_d_q.push_back({1'b1, 64'h0});
            else if (d_pw) begin
               ref_arr[d_pa[8:3]] = tb_merge(ref_arr[d_pa[8:3]], d_pd, d_ps);
               exp_d_q.push_back({1'b0, 64'h0});
            end else begin
               exp_d_q.push_back({1'b0, tb_merge(64'h0, ref_arr[d_pa[8:3]], d_ps)});
            end
            d_pend = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      apply();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_idle(input string name);
      int n;
      n = 0;
      do begin
         cyc();
         n++;
      end while ((i_pend || d_pend) && n < 50);
      if (i_pend || d_pend) begin
         chk({name, "_timeout"}, 1'b1, 1'b0);
         i_pend = 1'b0;
         d_pend = 1'b0;
      end
   endtask

   function automatic logic [63:0] rand_addr();
      case ($urandom_range(0, 11))
         0:       return 64'h0000_0000_9000_0000;
         1:       return 64'h0000_0000_7FFF_FFF8;
         2:       return 64'h0000_0000_8800_0000;
         3:       return 64'h0000_0000_87FF_FFF8;
         4:       return 64'hFFFF_FFFF_8000_0000;
         default: return BASE + 64'($urandom_range(0, NW - 1)) * 64'd8;
      endcase
   endfunction

   // ---------------- monitor ----------------
   logic tb_last_data;  // side granted most recently; reset behaves as data
   logic prev_i_gnt, prev_d_gnt;

   always @(negedge clk) begin
      logic i_el, d_el, e_i, e_d;
      logic [9:0]   e_ctrl;
      logic [127:0] e_ad;
      if (!rst_n) begin
         tb_last_data = 1'b1;
         prev_i_gnt   = 1'b0;
         prev_d_gnt   = 1'b0;
      end else begin
         // Round-robin grant model.
         i_el = bus.i_req && (!bus.i_rvalid || bus.i_rready);
         d_el = bus.d_req && (!bus.d_rvalid || bus.d_rready);
         e_i  = i_el && (!d_el || tb_last_data);
         e_d  = d_el && (!i_el || !tb_last_data);
         chk("grant", {bus.i_gnt, bus.d_gnt}, {e_i, e_d});
         if (bus.i_gnt) tb_last_data = 1'b0;
         else if (bus.d_gnt) tb_last_data = 1'b1;

         // Memory port contents for this cycle.
         e_ctrl = '0;
         e_ad   = '0;
         if (bus.i_gnt && tb_in_win(bus.i_addr)) begin
            e_ctrl = {1'b1, 1'b0, 8'h0F};
            e_ad   = {bus.i_addr, 64'h0};
         end else if (bus.d_gnt && tb_in_win(bus.d_addr)) begin
            e_ctrl = {1'b1, bus.d_wr, bus.d_strb};
            e_ad   = {bus.d_addr, bus.d_wdata};
         end
         chk("m_ctrl", {bus.m_en, bus.m_wr, bus.m_strb}, e_ctrl);
         chk("m_addr_wdata", {bus.m_addr, bus.m_wdata}, e_ad);

         // One-cycle response latency.
         if (prev_i_gnt) chk("i_latency", bus.i_rvalid, 1'b1);
         if (prev_d_gnt) chk("d_latency", bus.d_rvalid, 1'b1);
         prev_i_gnt = bus.i_gnt;
         prev_d_gnt = bus.d_gnt;

         // Response transfers.
         if (bus.i_rvalid && bus.i_rready) begin
            if (exp_i_q.size() == 0) chk("i_resp_unexpected", 1'b1, 1'b0);
            else chk("i_resp", {bus.i_err, bus.i_rdata}, exp_i_q.pop_front());
         end
         if (bus.d_rvalid && bus.d_rready) begin
            if (exp_d_q.size() == 0) chk("d_resp_unexpected", 1'b1, 1'b0);
            else chk("d_resp", {bus.d_err, bus.d_rdata}, exp_d_q.pop_front());
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_n  = 1'b0;
      i_pend = 1'b0; i_rr = 1'b0; i_pa = '0;
      d_pend = 1'b0; d_pw = 1'b0; d_rr = 1'b0; d_ps = '0; d_pa = '0; d_pd = '0;
      for (int i = 0; i < NW; i++) ref_arr[i] = seed_word(i);
      apply();
      repeat (3) @(posedge clk);
      #1;

      // Reset values.
      chk("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
      chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 96'h0);
      chk("rst_err", {bus.i_err, bus.d_err}, 2'b00);
      chk("rst_last_d", bus.last_d, 1'b0);
      chk("rst_slot_state", {bus.i_slot_state, bus.d_slot_state}, {SLOT_EMPTY, SLOT_EMPTY});
      chk("rst_m_port", {bus.m_en, bus.m_wr, bus.m_strb, bus.m_addr, bus.m_wdata}, 138'h0);
      rst_n = 1'b1;

      // Contested, both draining: I, D, I, D, ... starting with fetch.
      i_rr = 1'b1;
      d_rr = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (!i_pend) begin i_pend = 1'b1; i_pa = BASE + 64'd8 * 64'(k + 1); end
         if (!d_pend) begin
            d_pend = 1'b1; d_pw = 1'b0; d_ps = 8'hFF; d_pa = BASE + 64'd8 * 64'(k + 20);
         end
         cyc();
         chk("alt_i_gnt", obs_i_gnt, (k % 2) == 0);
         chk("alt_d_gnt", obs_d_gnt, (k % 2) == 1);
      end
      run_until_idle("alt_drain");
      repeat (2) cyc();

      // Fetch only at the window base.
      i_pend = 1'b1; i_pa = BASE;
      cyc();
      chk("fetch_gnt", obs_i_gnt, 1'b1);
      chk("fetch_rvalid", bus.i_rvalid, 1'b1);
      chk("fetch_rdata", bus.i_rdata, 32'h0000_0513);
      chk("fetch_err", bus.i_err, 1'b0);
      cyc();

      // Store then load of the same address in the next cycle.
      d_pend = 1'b1; d_pw = 1'b1; d_ps = 8'hFF; d_pa = BASE + 64'h10;
      d_pd = 64'h1122_3344_5566_7788;
      cyc();
      chk("store_gnt", obs_d_gnt, 1'b1);
      d_pend = 1'b1; d_pw = 1'b0; d_ps = 8'h0F; d_pa = BASE + 64'h10;
      cyc();
      chk("load_gnt", obs_d_gnt, 1'b1);
      chk("load_rvalid", bus.d_rvalid, 1'b1);
      chk("load_rdata", bus.d_rdata, 64'h0000_0000_5566_7788);
      cyc();

      // Out-of-window load.
      d_pend = 1'b1; d_pw = 1'b0; d_ps = 8'hFF; d_pa = 64'h0000_0000_9000_0000;
      cyc();
      chk("oow_gnt", obs_d_gnt, 1'b1);
      chk("oow_m_en", obs_m_en, 1'b0);
      chk("oow_resp", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {1'b1, 1'b1, 64'h0});
      cyc();

      // Back-pressure on the fetch slot.
      i_rr = 1'b0;
      i_pend = 1'b1; i_pa = BASE + 64'h40;
      cyc();
      chk("bp_first_gnt", obs_i_gnt, 1'b1);
      i_pend = 1'b1; i_pa = BASE + 64'h48;
      cyc();
      chk("bp_no_gnt", obs_i_gnt, 1'b0);
      chk("bp_hold", {bus.i_rvalid, bus.i_rdata}, {1'b1, ref_arr[8][31:0]});
      i_rr = 1'b1;
      cyc();
      chk("bp_regnt", obs_i_gnt, 1'b1);
      chk("bp_new_data", {bus.i_rvalid, bus.i_rdata}, {1'b1, ref_arr[9][31:0]});
      cyc();

      // Reset while a data response is held and a store is requested.
      d_rr = 1'b0;
      d_pend = 1'b1; d_pw = 1'b0; d_ps = 8'hFF; d_pa = BASE + 64'h20;
      cyc();
      chk("mrst_setup_rvalid", bus.d_rvalid, 1'b1);
      d_pend = 1'b1; d_pw = 1'b1; d_ps = 8'hFF; d_pa = BASE + 64'h28;
      d_pd = 64'hDEAD_BEEF_0BAD_F00D;
      d_rr = 1'b1;
      rst_n = 1'b0;
      apply();
      #1;
      chk("mrst_rvalid", bus.d_rvalid, 1'b0);
      chk("mrst_m_en", bus.m_en, 1'b0);
      chk("mrst_gnt", bus.d_gnt, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("mrst_mem_unchanged", mem_arr[5], ref_arr[5]);
      exp_i_q.delete();
      exp_d_q.delete();
      d_pend = 1'b0;
      apply();
      rst_n = 1'b1;

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         if (!i_pend && $urandom_range(0, 99) < 60) begin
            i_pend = 1'b1; i_pa = rand_addr();
         end
         if (!d_pend && $urandom_range(0, 99) < 60) begin
            d_pend = 1'b1;
            d_pw   = 1'($urandom_range(0, 1));
            d_ps   = 8'($urandom_range(0, 255));
            d_pa   = rand_addr();
            d_pd   = {$urandom(), $urandom()};
         end
         i_rr = ($urandom_range(0, 99) < 70);
         d_rr = ($urandom_range(0, 99) < 70);
         cyc();
      end

      // Drain and final consistency.
      i_rr = 1'b1;
      d_rr = 1'b1;
      run_until_idle("rand_drain");
      repeat (3) cyc();
      chk("i_queue_empty", 32'(exp_i_q.size()), 32'd0);
      chk("d_queue_empty", 32'(exp_d_q.size()), 32'd0);
      for (int i = 0; i < NW; i++) chk("final_mem", mem_arr[i], ref_arr[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 128 MB memory port (window 0x8000_0000–0x87FF_FFFF, combinational read, write committed at clock edge) between the instruction-fetch requester and the load/store requester. Arbitrates round-robin per cycle, range-checks addresses, drives the memory port for exactly the granted cycle, and returns each result through a registered, back-pressurable response slot per requester. Sits between the core's fetch/LSU stages and `memory`.

## Interface
- `MEM_BASE`, 64'h0000_0000_8000_0000, first byte of the memory window
- `MEM_AW`, 27, window address bits (window size 2^MEM_AW bytes)
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `i_req` in 1: fetch request valid; `i_addr` held stable until granted
- `i_addr` in 64: fetch byte address
- `i_gnt` out 1: fetch request accepted this cycle
- `i_rvalid` out 1: fetch response held in slot
- `i_rready` in 1: fetch consumer accepts response
- `i_rdata` out 32: fetched instruction
- `i_err` out 1: fetch address outside window
- `d_req` in 1: data request valid; all `d_*` inputs held until granted
- `d_wr` in 1: 1 = store, 0 = load
- `d_strb` in 8: byte enables
- `d_addr` in 64: data byte address
- `d_wdata` in 64: store data
- `d_gnt` out 1: data request accepted this cycle
- `d_rvalid` / `d_rready` out/in 1: data response handshake
- `d_rdata` out 64: load data (masked by strobes), 0 for stores
- `d_err` out 1: data address outside window
- `m_en`, `m_wr` out 1; `m_strb` out 8; `m_addr`, `m_wdata` out 64; `m_rdata` in 64: memory port

## Operation
- In-window: `addr[63:MEM_AW] == MEM_BASE[63:MEM_AW]`.
- Side X eligible when `X_req && (!X_rvalid || X_rready)` (slot empty or draining this cycle).
- One eligible side: granted. Both eligible: side not granted last grant wins (`last_d` flag, reset 0 → fetch wins first tie).
- Granted, in-window fetch: `m_en=1, m_wr=0, m_strb=8'h0F, m_addr=i_addr`; slot captures `m_rdata[31:0]`, `err=0`.
- Granted, in-window data: `m_en=1, m_wr=d_wr, m_strb=d_strb, m_addr=d_addr, m_wdata=d_wdata`; load captures `m_rdata`, store captures 0; `err=0`.
- Granted, out-of-window: `m_en=0`; slot captures data 0, `err=1`. No memory side effect.
- No grant: `m_en=0, m_wr=0, m_strb=0, m_addr=0, m_wdata=0`.
- Response slot per side, states EMPTY/FULL: EMPTY→FULL on grant; FULL→EMPTY on `rready` without grant; FULL→FULL (new data) on `rready` with grant. Slot content only changes on grant.
- `m_en` forced 0 while `rst_n` low.

## Timing
- Grant and memory port combinational from `*_req`, slot state, `last_d` in same cycle.
- Response latency 1: grant in cycle N → `X_rvalid=1` from cycle N+1 until accepted.
- Throughput: one access per cycle total; a side with `rready` held high may be granted every cycle when uncontested, every other cycle when contested.
- Store commits at end of grant cycle; a load granted in N+1 to same address reads new data.
- Reset values: `i_rvalid=d_rvalid=0`, `i_rdata=0`, `d_rdata=0`, `i_err=d_err=0`, `last_d=0`, all `m_*` 0.
- Reset mid-operation: pending responses discarded; no write issued in reset cycle.

## Structure
- Package `mem_pkg`: `MEM_BASE`, `MEM_AW`, slot state enum (`SLOT_EMPTY`, `SLOT_FULL`), fetch strobe constant 8'h0F.
- Sub-module `mem_resp_slot` (parameterised data width 32/64): one-entry registered response buffer with valid/ready and err bit; instantiated twice.
- Arbitration and port muxing in the top module.

## Test plan
- Fetch only, `i_addr=0x8000_0000`, memory word 0x0000_0513, `i_rready=1` → `i_gnt` cycle 0, `i_rvalid=1`, `i_rdata=0x0000_0513`, `i_err=0` cycle 1.
- Store `d_addr=0x8000_0010, d_strb=0xFF, d_wdata=0x1122_3344_5566_7788`, then load same address strb 0x0F → load `d_rdata=0x0000_0000_5566_7788`.
- Both requesting continuously, both `rready=1` → grants alternate I,D,I,D starting with I after reset.
- `d_addr=0x9000_0000` load → `m_en=0` in grant cycle, `d_rvalid=1, d_err=1, d_rdata=0` next cycle.
- `i_rready=0` with `i_rvalid=1` and `i_req=1` → `i_gnt=0`, slot holds; raise `i_rready` → regrant same cycle, new data next cycle.
- Assert `rst_n=0` while `d_rvalid=1` and `d_req=1, d_wr=1` → `d_rvalid` clears immediately, `m_en=0`, memory unchanged.
